serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor computing diff = a - b. Processes one bit per clock,
//  LSB first, through a single full-subtractor cell and a registered borrow.

---
 rtl/sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_subtractor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtract path: FSM state codes and default width.
package sub_pkg;

    localparam int SUB_DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, with start/busy/done handshake.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             borrow_q, borrow_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New difference bit enters at the MSB so after WIDTH shifts the LSB lands at bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = fs_d;
        end else begin : g_res_wn
            assign res_shift = {fs_d, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        bitcnt_d = bitcnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_d    = res_shift;
                borrow_d = fs_bout;
                bitcnt_d = bitcnt_q + BCW'(1);
                if (bitcnt_q == LAST_BIT) begin
                    diff_d  = res_shift;
                    bout_d  = fs_bout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            bitcnt_q <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            bitcnt_q <= bitcnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1;
    logic       a1, b1;
    logic       busy1, done1, bout1, diff1;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation; optionally pulses start with other operands mid-RUN.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit inject,
                       input bit verbose, input string tag);
        logic [8:0] exp;
        int cyc, busy_cnt, extra;
        bit seen;
        exp = {1'b0, av} - {1'b0, bv};
        @(negedge clk);
        start8 = 1'b1;
        a8 = av;
        b8 = bv;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cyc = 0;
        busy_cnt = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy8) busy_cnt++;
            if (inject && cyc == 3) begin
                start8 = 1'b1;
                a8 = 8'h10;
                b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            if (done8) seen = 1;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'd9);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, " diff"}, 32'(diff8), 32'(exp[7:0]));
        chk({tag, " bout"}, 32'(bout8), 32'(exp[8]));
        if (verbose)
            $display("op8 %s a=%02h b=%02h diff=%02h bout=%0d lat=%0d", tag, av, bv, diff8, bout8, cyc);
        @(negedge clk);
        chk({tag, " done_width"}, 32'(done8), 32'd0);
        chk({tag, " diff_hold"}, 32'(diff8), 32'(exp[7:0]));
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (done8) extra++;
            end
            chk({tag, " extra_done"}, 32'(extra), 32'd0);
            chk({tag, " diff_after_inject"}, 32'(diff8), 32'(exp[7:0]));
        end
    endtask

    task automatic op1(input logic av, input logic bv);
        logic [1:0] exp;
        int cyc;
        bit seen;
        exp = {1'b0, av} - {1'b0, bv};
        @(negedge clk);
        start1 = 1'b1;
        a1 = av;
        b1 = bv;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        a1 = ~av;
        b1 = ~bv;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (done1) seen = 1;
        end
        chk("w1 done_seen", 32'(seen), 32'd1);
        chk("w1 latency", 32'(cyc), 32'd2);
        chk("w1 diff", 32'(diff1), 32'(exp[0]));
        chk("w1 bout", 32'(bout1), 32'(exp[1]));
        $display("op1 a=%0d b=%0d d=%0d bout=%0d", av, bv, diff1, bout1);
        @(negedge clk);
    endtask

    initial begin
        int dcnt;
        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy8), 32'd0);
        chk("rst done", 32'(done8), 32'd0);
        chk("rst diff", 32'(diff8), 32'd0);
        chk("rst bout", 32'(bout8), 32'd0);
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 1'b0, 1'b1, "t1");
        op8(8'h03, 8'h05, 1'b0, 1'b1, "t2a");
        op8(8'h00, 8'h01, 1'b0, 1'b1, "t2b");
        op8(8'hFF, 8'hFF, 1'b0, 1'b1, "t3a");
        op8(8'h00, 8'h00, 1'b0, 1'b1, "t3b");
        op8(8'hA7, 8'h3C, 1'b1, 1'b1, "t4");

        // Abort mid-RUN: a prior nonzero diff must clear at once.
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'h12;
        b8 = 8'h34;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5 busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5 busy", 32'(busy8), 32'd0);
        chk("t5 diff", 32'(diff8), 32'd0);
        chk("t5 bout", 32'(bout8), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            if (done8) dcnt++;
        end
        chk("t5 no_done", 32'(dcnt), 32'd0);
        $display("reset abort: busy=%0d diff=%02h bout=%0d", busy8, diff8, bout8);
        op8(8'h40, 8'h41, 1'b0, 1'b1, "t5_after");

        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom), 1'b0, 1'b1, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
